// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game controller.
package snake_pkg;

  // Game sequencer states; encoding is visible on the state port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam int SCORE_W = 7;
  localparam int LEVEL_W = 3;

  // Move-tick period in cycles for a given speed level.
  function automatic int tick_period(input int base, input int step, input int lvl);
    return base - lvl * step;
  endfunction

endpackage

// File: rtl/snake_edge_det.sv
// One-bit rising-edge detector for synchronized button levels.
// rise is high in the cycle where btn is 1 and was 0 in the previous cycle.
module snake_edge_det (
  input  logic clk,
  input  logic nRst,
  input  logic btn,
  output logic rise
);

  logic btn_q;

  // Previous-cycle copy of the button level.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn;
    end
  end

  assign rise = btn & ~btn_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: IDLE/RUN/PAUSE/OVER state machine, level-scaled
// move tick, and gated collision forwarding to the score tracker.
// Optional feature macro: SNAKE_PAUSE_EN (pause state and pause edge logic).
//
// Pulse semantics: good_coll_out, bad_coll_out and move_tick are single-cycle
// strobes with no back-pressure; a consumer must act in the cycle they are high.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int BASE_PERIOD = 50,
  parameter int PERIOD_STEP = 4,
  parameter int LEVEL_SCORE = 10,
  parameter int MAX_LEVEL   = 7,
  parameter int OVER_HOLD   = 16
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               good_coll_in,
  input  logic               bad_coll_in,
  input  logic               game_complete,
  output logic               good_coll_out,
  output logic               bad_coll_out,
  output logic               move_tick,
  output logic               snake_rst,
  output game_state_t        state,
  output logic [LEVEL_W-1:0] level
);

  localparam int CNT_W  = $clog2(BASE_PERIOD + 1);
  localparam int HOLD_W = $clog2(OVER_HOLD + 1);

`ifdef SNAKE_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  // Pause button is kept on the port list but never acts.
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic               start_edge;
  logic               pause_rise;
  logic               pause_edge;
  logic [CNT_W-1:0]   tick_cnt;
  logic [CNT_W-1:0]   reload_val;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [SCORE_W-1:0] pts;

  snake_edge_det u_start_edge (
    .clk  (clk),
    .nRst (nRst),
    .btn  (start_btn),
    .rise (start_edge)
  );

  snake_edge_det u_pause_edge (
    .clk  (clk),
    .nRst (nRst),
    .btn  (pause_btn),
    .rise (pause_rise)
  );

  assign pause_edge = pause_rise & PAUSE_EN;

  // Reload value uses the level register as it stands, so a level change
  // only alters the spacing from the next reload onward.
  assign reload_val = CNT_W'(tick_period(BASE_PERIOD, PERIOD_STEP, int'(level)) - 1);

  // Strobes decoded purely from registered state: tick while running with an
  // expired counter (also on the cycle the game leaves RUN), body reset while idle.
  assign move_tick = (state == RUN) && (tick_cnt == '0);
  assign snake_rst = (state == IDLE);

  // Game state machine with its counters and registered collision pulses.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state         <= IDLE;
      level         <= '0;
      pts           <= '0;
      tick_cnt      <= '0;
      hold_cnt      <= '0;
      good_coll_out <= 1'b0;
      bad_coll_out  <= 1'b0;
    end else begin
      good_coll_out <= 1'b0;
      bad_coll_out  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_edge) begin
            state    <= RUN;
            level    <= '0;
            pts      <= '0;
            tick_cnt <= CNT_W'(BASE_PERIOD - 1);
          end
        end

        RUN: begin
          // Counter keeps running on every RUN cycle, including the one
          // that enters PAUSE, so a pause neither loses nor gains cycles.
          if (tick_cnt == '0) begin
            tick_cnt <= reload_val;
          end else begin
            tick_cnt <= tick_cnt - CNT_W'(1);
          end

          // Priority: bad > game_complete > pause edge > good.
          if (bad_coll_in) begin
            bad_coll_out <= 1'b1;
            state        <= OVER;
            hold_cnt     <= HOLD_W'(OVER_HOLD - 1);
          end else if (game_complete) begin
            state    <= OVER;
            hold_cnt <= HOLD_W'(OVER_HOLD - 1);
          end else if (pause_edge) begin
            state <= PAUSE;
          end else if (good_coll_in) begin
            good_coll_out <= 1'b1;
            if (pts == SCORE_W'(LEVEL_SCORE - 1)) begin
              pts <= '0;
              if (level != LEVEL_W'(MAX_LEVEL)) begin
                level <= level + LEVEL_W'(1);
              end
            end else begin
              pts <= pts + SCORE_W'(1);
            end
          end
        end

        PAUSE: begin
          // Everything frozen; only another pause edge resumes play.
          if (pause_edge) begin
            state <= RUN;
          end
        end

        OVER: begin
          // hold_cnt counts OVER_HOLD-1 down to 0, one value per cycle.
          if (hold_cnt == '0) begin
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Randomized scoreboard bench for snake_game_ctrl with a behavioural model.
module tb_snake_game_ctrl;
  import snake_pkg::*;

  localparam int BASE_PERIOD = 50;
  localparam int PERIOD_STEP = 4;
  localparam int LEVEL_SCORE = 10;
  localparam int MAX_LEVEL   = 7;
  localparam int OVER_HOLD   = 16;
  localparam int W           = 9;

`ifdef SNAKE_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nRst = 1'b0;
  always #5 clk = ~clk;

  logic start_btn = 1'b0;
  logic pause_btn = 1'b0;
  logic good_coll_in = 1'b0;
  logic bad_coll_in = 1'b0;
  logic game_complete = 1'b0;
  logic good_coll_out, bad_coll_out, move_tick, snake_rst;
  game_state_t dut_state;
  logic [LEVEL_W-1:0] level;

  snake_game_ctrl #(
    .BASE_PERIOD (BASE_PERIOD),
    .PERIOD_STEP (PERIOD_STEP),
    .LEVEL_SCORE (LEVEL_SCORE),
    .MAX_LEVEL   (MAX_LEVEL),
    .OVER_HOLD   (OVER_HOLD)
  ) dut (
    .clk           (clk),
    .nRst          (nRst),
    .start_btn     (start_btn),
    .pause_btn     (pause_btn),
    .good_coll_in  (good_coll_in),
    .bad_coll_in   (bad_coll_in),
    .game_complete (game_complete),
    .good_coll_out (good_coll_out),
    .bad_coll_out  (bad_coll_out),
    .move_tick     (move_tick),
    .snake_rst     (snake_rst),
    .state         (dut_state),
    .level         (level)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: phase 0 idle, 1 run, 2 pause, 3 over.
  int m_phase = 0;
  int m_remaining = 0;   // RUN cycles up to and including the next tick
  int m_goods = 0;       // forwarded goods since the game started
  int m_over_left = 0;   // OVER cycles still to spend
  bit m_sprev = 1'b0;
  bit m_pprev = 1'b0;

  function automatic int m_level();
    int l;
    l = m_goods / LEVEL_SCORE;
    return (l > MAX_LEVEL) ? MAX_LEVEL : l;
  endfunction

  function automatic int m_period(input int lvl);
    return BASE_PERIOD - lvl * PERIOD_STEP;
  endfunction

  task automatic model_step();
    bit sedge, pedge, n_good, n_bad, n_tick;
    logic [W-1:0] e;
    sedge = start_btn && !m_sprev;
    pedge = PAUSE_EN && pause_btn && !m_pprev;
    m_sprev = start_btn;
    m_pprev = pause_btn;
    n_good = 1'b0;
    n_bad = 1'b0;
    case (m_phase)
      0: if (sedge) begin
           m_phase = 1;
           m_goods = 0;
           m_remaining = BASE_PERIOD;
         end
      1: begin
           if (m_remaining == 1) m_remaining = m_period(m_level());
           else m_remaining = m_remaining - 1;
           if (bad_coll_in) begin
             n_bad = 1'b1;
             m_phase = 3;
             m_over_left = OVER_HOLD;
           end else if (game_complete) begin
             m_phase = 3;
             m_over_left = OVER_HOLD;
           end else if (pedge) begin
             m_phase = 2;
           end else if (good_coll_in) begin
             n_good = 1'b1;
             m_goods = m_goods + 1;
           end
         end
      2: if (pedge) m_phase = 1;
      default: begin
           m_over_left = m_over_left - 1;
           if (m_over_left == 0) m_phase = 0;
         end
    endcase
    n_tick = (m_phase == 1) && (m_remaining == 1);
    e = {2'(m_phase), 3'(m_level()), n_tick, (m_phase == 0), n_good, n_bad};
    exp_q.push_back(e);
  endtask

  // Model advances on every active edge; reset clears it and the queue.
  initial begin
    forever begin
      @(posedge clk or negedge nRst);
      if (!nRst) begin
        m_phase = 0;
        m_remaining = 0;
        m_goods = 0;
        m_over_left = 0;
        m_sprev = 1'b0;
        m_pprev = 1'b0;
        exp_q.delete();
      end else begin
        model_step();
      end
    end
  end

  // Monitor: compare DUT outputs against the oldest expectation.
  initial begin
    logic [W-1:0] act, exp;
    forever begin
      @(negedge clk);
      if (nRst && exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act = {dut_state, level, move_tick, snake_rst, good_coll_out, bad_coll_out};
        vectors++;
        if (act !== exp) begin
          miscompares++;
          $display("FAIL outputs t=%0t got st=%0d lvl=%0d tick=%b rst=%b good=%b bad=%b want st=%0d lvl=%0d tick=%b rst=%b good=%b bad=%b",
                   $time, act[8:7], act[6:4], act[3], act[2], act[1], act[0],
                   exp[8:7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, int'(dut_state), 0);
    check({tag, "_level"}, int'(level), 0);
    check({tag, "_snake_rst"}, int'(snake_rst), 1);
    check({tag, "_move_tick"}, int'(move_tick), 0);
    check({tag, "_good_out"}, int'(good_coll_out), 0);
    check({tag, "_bad_out"}, int'(bad_coll_out), 0);
  endtask

  task automatic cyc(input bit s, input bit p, input bit g, input bit b, input bit gc);
    @(negedge clk);
    #1;
    start_btn = s;
    pause_btn = p;
    good_coll_in = g;
    bad_coll_in = b;
    game_complete = gc;
  endtask

  function automatic bit chance(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic run_rand(input int n, input int s_pct, input int p_pct,
                          input int g_pct, input int b_pct, input int gc_pct);
    for (int i = 0; i < n; i++)
      cyc(chance(s_pct), chance(p_pct), chance(g_pct), chance(b_pct), chance(gc_pct));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_reset("reset_init");
    nRst = 1'b1;
    repeat (5) cyc(0, 0, 0, 0, 0);

    // Start edge then a held start level: ticks every 50, no restart.
    for (int i = 0; i < 160; i++) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Goods until level 3, then asynchronous reset mid-game.
    for (int i = 0; i < 600 && m_level() < 3; i++) cyc(0, 0, chance(35), 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, chance(35), 0, 0);
    @(negedge clk);
    #3;
    nRst = 1'b0;
    #1;
    check_reset("reset_midrun");
    repeat (2) @(negedge clk);
    #1;
    nRst = 1'b1;

    // New game, drive level to saturation and watch spacing settle.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000 && m_level() < MAX_LEVEL; i++) cyc(0, 0, chance(40), 0, 0);
    for (int i = 0; i < 150; i++) cyc(0, 0, chance(40), 0, 0);

    // Good with bad in one cycle, then a start edge inside OVER.
    cyc(0, 0, 1, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    repeat (20) cyc(0, 0, 0, 0, 0);

    // Pause window with collision activity inside it.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) cyc(0, 0, chance(30), 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 100; i++) cyc(0, 0, chance(30), PAUSE_EN && chance(10), 0);
    cyc(0, 1, 0, 0, 0);
    repeat (60) cyc(0, 0, 0, 0, 0);

    // game_complete in RUN without a bad collision.
    repeat (OVER_HOLD + 2) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1);
    repeat (OVER_HOLD + 4) cyc(0, 0, 0, 0, 0);

    // Random soak across several games.
    run_rand(3000, 3, 3, 25, 1, 1);

    repeat (3) cyc(0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
